// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: MEM-stage sequencer state encoding
// and the positions of the memory-access bits in the control bundle.
package mips_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int SIG_MEMREAD_BIT  = 0;
    localparam int SIG_MEMWRITE_BIT = 1;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_BUSY = ST_BUSY,
        S_DONE = ST_DONE
    } mem_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles without an acknowledge and flags the cycle on which
// the access has waited TIMEOUT_CYC cycles.
module mem_timeout_ctr #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // The count reaches TIMEOUT_CYC-1 during the TIMEOUT_CYC-th waiting cycle.
    localparam logic [7:0] LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] count;

    // Restart on a new access, otherwise advance once per unacknowledged cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= 8'd0;
        else if (clear)
            count <= 8'd0;
        else if (enable)
            count <= count + 8'd1;
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/register.sv
// Generic loadable register with asynchronous active-high clear.
module register #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d when load is high; clear on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs one req/ack transaction per load or store
// against a variable-latency data memory, stalling the upstream buffers
// and feeding bubbles to MEM/WB until the access completes.
// Optional build macro MEM_TIMEOUT_EN adds an abort after TIMEOUT_CYC
// unacknowledged BUSY cycles and a sticky err flag.
module mem_stage_ctrl
    import mips_pkg::*;
#(
    parameter int SIG_W       = 8,
    parameter int RD_BIT      = SIG_MEMREAD_BIT,
    parameter int WR_BIT      = SIG_MEMWRITE_BIT,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [SIG_W-1:0] signals_in,
    input  logic [31:0]      addr_in,
    input  logic [31:0]      wdata_in,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             stall,
    output logic [SIG_W-1:0] signals_out,
    output logic [31:0]      rdata_out,
    output logic             err
);

    mem_state_t  state;
    mem_state_t  state_nxt;

    logic        acc;
    logic        start;
    logic        ack_seen;
    logic        timeout;
    logic        rdata_load;
    logic [31:0] rdata_d;

    assign acc = valid_in & (signals_in[RD_BIT] | signals_in[WR_BIT]);

    // ack is only meaningful while a request is outstanding (BUSY).
    assign ack_seen = (state == S_BUSY) & mem_ack;

`ifdef MEM_TIMEOUT_EN
    logic err_q;

    mem_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (start),
        .enable  ((state == S_BUSY) & ~mem_ack),
        .expired (timeout)
    );

    // Sticky error: set on the first abort, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else if (timeout)
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // Loads capture returned data; an abort zeroes it; stores leave it alone.
    assign rdata_load = (ack_seen & ~mem_we) | timeout;
    assign rdata_d    = timeout ? 32'd0 : mem_rdata;

    register #(32) u_rdata (
        .clock (clock),
        .reset (reset),
        .load  (rdata_load),
        .d     (rdata_d),
        .q     (rdata_out)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next state, stall and bubble insertion.
    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        start       = 1'b0;
        signals_out = signals_in;
        case (state)
            S_IDLE: begin
                if (acc) begin
                    stall       = 1'b1;
                    start       = 1'b1;
                    signals_out = '0;
                    state_nxt   = S_BUSY;
                end
            end
            S_BUSY: begin
                stall       = 1'b1;
                signals_out = '0;
                if (ack_seen || timeout)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Memory port: raise and latch on access start, drop on completion or abort.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else if (start) begin
            mem_req   <= 1'b1;
            mem_we    <= signals_in[WR_BIT];
            mem_addr  <= addr_in;
            mem_wdata <= wdata_in;
        end else if (ack_seen || timeout) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: reset, ALU pass-through, load, store,
// back-to-back loads and (with MEM_TIMEOUT_EN) the timeout abort.
module tb_mem_stage_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [7:0]  signals_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [7:0]  signals_out;
    logic [31:0] rdata_out;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage_ctrl #(
        .SIG_W       (8),
        .RD_BIT      (0),
        .WR_BIT      (1),
        .TIMEOUT_CYC (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .valid_in    (valid_in),
        .signals_in  (signals_in),
        .addr_in     (addr_in),
        .wdata_in    (wdata_in),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .stall       (stall),
        .signals_out (signals_out),
        .rdata_out   (rdata_out),
        .err         (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        valid_in   = 1'b0;
        signals_in = 8'h00;
        addr_in    = 32'd0;
        wdata_in   = 32'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        #2;
        chk("rst_req",   32'(mem_req),   32'd0);
        chk("rst_addr",  mem_addr,       32'd0);
        chk("rst_stall", 32'(stall),     32'd0);
        chk("rst_err",   32'(err),       32'd0);
        chk("rst_rdata", rdata_out,      32'd0);
        step();
        step();
        reset = 1'b0;

        // Reset while a load is outstanding
        valid_in = 1'b1; signals_in = 8'h01; addr_in = 32'h40;
        #1;
        chk("r1_stall_idle", 32'(stall), 32'd1);
        step();
        chk("r1_req_busy",  32'(mem_req), 32'd1);
        chk("r1_addr_busy", mem_addr,     32'h40);
        #2;
        reset = 1'b1;
        #1;
        chk("r1_req_async", 32'(mem_req), 32'd0);
        valid_in = 1'b0; signals_in = 8'h00;
        #1;
        chk("r1_stall", 32'(stall),  32'd0);
        chk("r1_err",   32'(err),    32'd0);
        chk("r1_rdata", rdata_out,   32'd0);
        step();
        reset = 1'b0;
        step();

        // ALU op passes straight through
        valid_in = 1'b1; signals_in = 8'h04; addr_in = 32'h80;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("alu_stall", 32'(stall),       32'd0);
            chk("alu_sig",   32'(signals_out), 32'h04);
            chk("alu_req",   32'(mem_req),     32'd0);
            step();
        end

        // Load, ack on the second BUSY cycle
        signals_in = 8'h01; addr_in = 32'h200; mem_rdata = 32'hCAFE0001;
        #1;
        chk("ld_stall1", 32'(stall),       32'd1);
        chk("ld_sig1",   32'(signals_out), 32'h00);
        step();
        chk("ld_req",    32'(mem_req),     32'd1);
        chk("ld_we",     32'(mem_we),      32'd0);
        chk("ld_addr",   mem_addr,         32'h200);
        chk("ld_stall2", 32'(stall),       32'd1);
        chk("ld_sig2",   32'(signals_out), 32'h00);
        step();
        chk("ld_stall3", 32'(stall),       32'd1);
        chk("ld_req3",   32'(mem_req),     32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        #1;
        chk("ld_done_stall", 32'(stall),       32'd0);
        chk("ld_done_sig",   32'(signals_out), 32'h01);
        chk("ld_done_req",   32'(mem_req),     32'd0);
        chk("ld_rdata",      rdata_out,        32'hCAFE0001);
        valid_in = 1'b0; signals_in = 8'h00;
        step();

        // Stray ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 32'hDEAD0000;
        step();
        mem_ack = 1'b0;
        #1;
        chk("stray_rdata", rdata_out,   32'hCAFE0001);
        chk("stray_req",   32'(mem_req), 32'd0);

        // Store, immediate ack; read data must be kept
        valid_in = 1'b1; signals_in = 8'h02; addr_in = 32'h100; wdata_in = 32'h55;
        #1;
        chk("st_stall1", 32'(stall), 32'd1);
        step();
        chk("st_req",   32'(mem_req), 32'd1);
        chk("st_we",    32'(mem_we),  32'd1);
        chk("st_addr",  mem_addr,     32'h100);
        chk("st_wdata", mem_wdata,    32'h55);
        chk("st_stall2", 32'(stall),  32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        step();
        mem_ack = 1'b0;
        #1;
        chk("st_done_stall", 32'(stall),       32'd0);
        chk("st_done_sig",   32'(signals_out), 32'h02);
        chk("st_done_req",   32'(mem_req),     32'd0);
        chk("st_rdata",      rdata_out,        32'hCAFE0001);
        step();

        // Back-to-back loads
        valid_in = 1'b1; signals_in = 8'h01; addr_in = 32'h300;
        #1;
        chk("bb1_stall", 32'(stall), 32'd1);
        step();
        chk("bb1_addr", mem_addr, 32'h300);
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        step();
        mem_ack = 1'b0;
        #1;
        chk("bb1_done_stall", 32'(stall),   32'd0);
        chk("bb1_done_req",   32'(mem_req), 32'd0);
        chk("bb1_rdata",      rdata_out,    32'h11111111);
        step();
        addr_in = 32'h304;
        #1;
        chk("bb2_idle_stall", 32'(stall),   32'd1);
        chk("bb2_idle_req",   32'(mem_req), 32'd0);
        step();
        chk("bb2_req",  32'(mem_req), 32'd1);
        chk("bb2_addr", mem_addr,     32'h304);
        mem_ack = 1'b1; mem_rdata = 32'h22222222;
        step();
        mem_ack = 1'b0;
        #1;
        chk("bb2_done_req", 32'(mem_req), 32'd0);
        chk("bb2_rdata",    rdata_out,    32'h22222222);
        valid_in = 1'b0; signals_in = 8'h00;
        step();

        // Load with no ack
        valid_in = 1'b1; signals_in = 8'h01; addr_in = 32'h400;
        #1;
        step();
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            chk("to_req_busy",   32'(mem_req), 32'd1);
            chk("to_stall_busy", 32'(stall),   32'd1);
            step();
        end
        chk("to_req_drop", 32'(mem_req), 32'd0);
        chk("to_stall",    32'(stall),   32'd0);
        chk("to_err",      32'(err),     32'd1);
        chk("to_rdata",    rdata_out,    32'd0);
        valid_in = 1'b0; signals_in = 8'h00;
        step();
        step();
        chk("to_err_sticky", 32'(err), 32'd1);
        chk("to_resume",     32'(stall), 32'd0);
`else
        for (int i = 0; i < 6; i++) begin
            chk("wait_req",   32'(mem_req), 32'd1);
            chk("wait_stall", 32'(stall),   32'd1);
            step();
        end
        chk("wait_err", 32'(err), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h33333333;
        step();
        mem_ack = 1'b0;
        #1;
        chk("wait_done_req", 32'(mem_req), 32'd0);
        chk("wait_rdata",    rdata_out,    32'h33333333);
        chk("wait_err2",     32'(err),     32'd0);
        valid_in = 1'b0; signals_in = 8'h00;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
